rn_stage_ctrl: RTL and testbench
================================

// Module: rn_stage_ctrl
// PURPOSE
//  Sequences the IF/ID and ID/RN pipeline registers of the out-of-order front end.
//  - Stalls them when the instruction in RN cannot dispatch: ROB full, reservation station (RS) full, or too few free physical registers.
//  - Flushes them on a redirect, then holds the front end empty until the rename map restore completes.
//  - Counts dispatch-stall cycles for performance analysis.
// PARAMETERS
//  NUM_FU         4   number of FU classes with an RS; FUType 1..NUM_FU index rs_full, 0 = no RS
//  PREG_CNT_W     7   width of the free-list count
//  MIN_FREE       1   minimum free physical regs required to rename a RegWrite instruction
//  RECOVER_MAX    16  max cycles in RECOVER before forced exit
//  CNT_W          32  stall counter width
// PORTS
//  clk             in   1           clock, all state on posedge
//  rst             in   1           synchronous, active-high reset
//  rn_valid        in   1           RN stage holds a valid (non-bubble) instruction
//  rn_regwrite     in   1           RN instruction needs a physical destination register
//  rn_futype       in   3           FU class of RN instruction
//  fl_count        in   PREG_CNT_W  free physical registers available
//  rob_full        in   1           ROB cannot accept an entry
//  rs_full         in   NUM_FU      per-FU RS full; bit i-1 <-> FUType i
//  redirect        in   1           1-cycle mispredict/exception pulse from commit
//  restore_done    in   1           rename map restore finished
//  if_id_stall     out  1           hold IF/ID register
//  if_id_flush     out  1           bubble IF/ID register
//  id_rn_stall     out  1           hold ID/RN register
//  id_rn_flush     out  1           bubble ID/RN register
//  rn_fire         out  1           RN instruction renames/dispatches this cycle
//  map_restore     out  1           1-cycle pulse: start rename map restore
//  recover_timeout out  1           sticky error: RECOVER exited by timeout
//  state_dbg       out  2           current FSM state
//  stall_cnt       out  CNT_W       saturating count of id_rn_stall cycles
// BEHAVIOUR
//  Dispatch block (combinational):
//   blk = rn_valid & (rob_full | rs_hit | (rn_regwrite & fl_count < MIN_FREE))
//   rs_hit = (1 <= rn_futype <= NUM_FU) ? rs_full[rn_futype-1] : (rn_futype != 0)
//   An out-of-range FUType blocks forever; this is intentional, to expose decode bugs.
//  FSM states: RUN = 0, FLUSH = 1, RECOVER = 2. Encoding 3 is illegal and goes to RUN.
//  RUN:
//   - Stall outputs: if_id_stall = id_rn_stall = blk & ~redirect.
//   - rn_fire = rn_valid & ~blk & ~redirect.
//   - On redirect: both flushes assert in the same cycle (combinational); next state is FLUSH.
//  FLUSH (exactly 1 cycle):
//   - Both flushes = 1, map_restore = 1, stalls = 0, rn_fire = 0.
//   - Next state is RECOVER; rcnt is cleared.
//  RECOVER:
//   - Both flushes = 1, stalls = 0, rn_fire = 0, rcnt increments each cycle.
//   - On restore_done: next state is RUN.
//   - Else if rcnt == RECOVER_MAX-1: next state is RUN and recover_timeout is set.
//  A redirect in FLUSH or RECOVER has priority over restore_done and the timeout.
//   It re-enters FLUSH, which re-pulses map_restore and clears rcnt.
//  Invariant: stall and flush are never both 1 on the same register. Flush always wins.
//  stall_cnt:
//   - +1 in every cycle with id_rn_stall = 1.
//   - Saturates at 2^CNT_W-1 (never wraps).
//   - Cleared only by rst.
//  Reset:
//   - State goes to RUN. rcnt, stall_cnt and recover_timeout go to 0.
//   - map_restore = 0.
//   - All stall/flush/fire outputs evaluate to 0 during the rst cycle.
//   - A reset mid-RECOVER aborts the recovery with no map_restore pulse.
//  Latency:
//   - Stall decision: 0 cycles.
//   - Redirect to first flush: 0 cycles.
//   - Redirect to map_restore: 1 cycle.
//   - restore_done to RUN: 1 cycle.
//   - Minimum flush window: 3 cycles (T, T+1, T+2).
// STRUCTURE
//  o3_pkg holds: FU type constants (FU_NONE=0, ALU, MEM, BRA, MUL), and the FSM state encodings RN_RUN, RN_FLUSH, RN_RECOVER.
//  One sub-module, sat_counter #(CNT_W): clk, rst, inc -> cnt, saturating. Used for stall_cnt.
//  All other logic is inline: state register, rcnt (clog2(RECOVER_MAX) bits), combinational blk/output decode.
// TESTING
//  1. Starvation stall: rn_valid=1, rn_regwrite=1, fl_count=0, MIN_FREE=1 for 5 cycles
//     -> both stalls=1 and rn_fire=0 each cycle; stall_cnt=5.
//     Then fl_count=3 -> stalls=0, rn_fire=1.
//  2. Full RS / no-RS type: rn_futype=2, rs_full=4'b0010 -> stalls=1.
//     Same with rn_futype=0 -> rn_fire=1. rn_futype=6 -> stalls=1.
//  3. Redirect with a pending stall: rob_full=1, redirect at T
//     -> T: flushes=1, stalls=0. T+1: map_restore=1, state=FLUSH.
//     restore_done at T+4 -> T+5: state=RUN, flushes=0.
//  4. Redirect in RECOVER: second redirect at T+3 -> T+4: state=FLUSH, map_restore pulses again, rcnt=0.
//     A restore_done asserted together with the redirect is ignored.
//  5. Timeout: RECOVER_MAX=8, no restore_done
//     -> exactly 8 cycles in RECOVER, then RUN with recover_timeout=1.
//     recover_timeout stays 1 until rst.
//  6. Saturation and reset: CNT_W=4, 20 stall cycles -> stall_cnt=15.
//     Assert rst while in RECOVER -> next cycle: state=RUN, stall_cnt=0, recover_timeout=0, all outputs 0.

Source files
------------

// File: rtl/o3_pkg.sv
// Shared front-end types: FU class codes and the RN stage controller state encodings.
package o3_pkg;

  localparam logic [2:0] FU_NONE = 3'd0;
  localparam logic [2:0] FU_ALU  = 3'd1;
  localparam logic [2:0] FU_MEM  = 3'd2;
  localparam logic [2:0] FU_BRA  = 3'd3;
  localparam logic [2:0] FU_MUL  = 3'd4;

  typedef enum logic [1:0] {
    RN_RUN     = 2'd0,
    RN_FLUSH   = 2'd1,
    RN_RECOVER = 2'd2
  } rn_state_e;

endpackage

// File: rtl/rn_stage_ctrl_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones, cleared by rst.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rn_stage_ctrl.sv
// Stalls/flushes the IF/ID and ID/RN registers: zero-cycle dispatch stall, redirect -> FLUSH -> RECOVER.
// Flush always overrides stall; stall cycles are counted in a saturating counter.
module rn_stage_ctrl
  import o3_pkg::*;
#(
  parameter int NUM_FU      = 4,
  parameter int PREG_CNT_W  = 7,
  parameter int MIN_FREE    = 1,
  parameter int RECOVER_MAX = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rn_valid,
  input  logic                  rn_regwrite,
  input  logic [2:0]            rn_futype,
  input  logic [PREG_CNT_W-1:0] fl_count,
  input  logic                  rob_full,
  input  logic [NUM_FU-1:0]     rs_full,
  input  logic                  redirect,
  input  logic                  restore_done,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_rn_stall,
  output logic                  id_rn_flush,
  output logic                  rn_fire,
  output logic                  map_restore,
  output logic                  recover_timeout,
  output logic [1:0]            state_dbg,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int RCNT_W = $clog2(RECOVER_MAX);
  localparam logic [PREG_CNT_W-1:0] MIN_FREE_W = PREG_CNT_W'(MIN_FREE);
  localparam logic [RCNT_W-1:0]     RCNT_LAST  = RCNT_W'(RECOVER_MAX - 1);

  rn_state_e         state_q, state_d;
  logic [RCNT_W-1:0] rcnt_q, rcnt_d;
  logic              recover_timeout_q, recover_timeout_d;

  logic rs_hit;
  logic blk;
  logic stall;
  logic flush;
  logic fire;
  logic restore;

  // Unknown FU classes (beyond NUM_FU) block permanently so decode bugs show up as hangs.
  always_comb begin
    rs_hit = (rn_futype != FU_NONE);
    for (int i = 1; i <= NUM_FU; i++) begin
      if (rn_futype == 3'(i)) begin
        rs_hit = rs_full[i-1];
      end
    end
  end

  assign blk = rn_valid & (rob_full | rs_hit | (rn_regwrite & (fl_count < MIN_FREE_W)));

  always_comb begin
    state_d           = state_q;
    rcnt_d            = rcnt_q;
    recover_timeout_d = recover_timeout_q;
    stall             = 1'b0;
    flush             = 1'b0;
    fire              = 1'b0;
    restore           = 1'b0;
    case (state_q)
      RN_RUN: begin
        stall = blk & ~redirect;
        fire  = rn_valid & ~blk & ~redirect;
        flush = redirect;
        if (redirect) begin
          state_d = RN_FLUSH;
        end
      end
      RN_FLUSH: begin
        flush   = 1'b1;
        restore = 1'b1;
        rcnt_d  = '0;
        state_d = redirect ? RN_FLUSH : RN_RECOVER;
      end
      RN_RECOVER: begin
        flush  = 1'b1;
        rcnt_d = rcnt_q + RCNT_W'(1);
        if (redirect) begin
          state_d = RN_FLUSH;
          rcnt_d  = '0;
        end else if (restore_done) begin
          state_d = RN_RUN;
        end else if (rcnt_q == RCNT_LAST) begin
          state_d           = RN_RUN;
          recover_timeout_d = 1'b1;
        end
      end
      default: begin
        state_d = RN_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= RN_RUN;
      rcnt_q            <= '0;
      recover_timeout_q <= 1'b0;
    end else begin
      state_q           <= state_d;
      rcnt_q            <= rcnt_d;
      recover_timeout_q <= recover_timeout_d;
    end
  end

  // Pipeline controls are forced quiet while rst is high, independent of the held state.
  assign if_id_stall     = stall & ~rst;
  assign id_rn_stall     = stall & ~rst;
  assign if_id_flush     = flush & ~rst;
  assign id_rn_flush     = flush & ~rst;
  assign rn_fire         = fire & ~rst;
  assign map_restore     = restore & ~rst;
  assign recover_timeout = recover_timeout_q;
  assign state_dbg       = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (id_rn_stall),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_rn_stage_ctrl.sv
// Directed bench for rn_stage_ctrl with RECOVER_MAX=8 and a 4-bit stall counter.
module tb_rn_stage_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rn_valid;
  logic       rn_regwrite;
  logic [2:0] rn_futype;
  logic [6:0] fl_count;
  logic       rob_full;
  logic [3:0] rs_full;
  logic       redirect;
  logic       restore_done;
  logic       if_id_stall, if_id_flush, id_rn_stall, id_rn_flush;
  logic       rn_fire, map_restore, recover_timeout;
  logic [1:0] state_dbg;
  logic [3:0] stall_cnt;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  rn_stage_ctrl #(
    .NUM_FU(4), .PREG_CNT_W(7), .MIN_FREE(1), .RECOVER_MAX(8), .CNT_W(4)
  ) dut (
    .clk(clk), .rst(rst), .rn_valid(rn_valid), .rn_regwrite(rn_regwrite),
    .rn_futype(rn_futype), .fl_count(fl_count), .rob_full(rob_full),
    .rs_full(rs_full), .redirect(redirect), .restore_done(restore_done),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_rn_stall(id_rn_stall), .id_rn_flush(id_rn_flush),
    .rn_fire(rn_fire), .map_restore(map_restore),
    .recover_timeout(recover_timeout), .state_dbg(state_dbg),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change 1 ns after the edge, checks happen 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic stall_tick();
    tick();
    if (exp_cnt < 15) exp_cnt++;
  endtask

  task automatic chk_ctl(input string tag, input logic stl, input logic fl, input logic fire);
    chk({tag, "_if_id_stall"}, 32'(if_id_stall), 32'(stl));
    chk({tag, "_id_rn_stall"}, 32'(id_rn_stall), 32'(stl));
    chk({tag, "_if_id_flush"}, 32'(if_id_flush), 32'(fl));
    chk({tag, "_id_rn_flush"}, 32'(id_rn_flush), 32'(fl));
    chk({tag, "_rn_fire"}, 32'(rn_fire), 32'(fire));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rn_valid = 1'b1; rn_regwrite = 1'b1; rn_futype = 3'd1;
    fl_count = 7'd0; rob_full = 1'b1; rs_full = 4'hF; redirect = 1'b1;
    restore_done = 1'b0;
    settle();
    chk_ctl("rst_cycle", 0, 0, 0);
    chk("rst_map_restore", 32'(map_restore), 0);
    tick();
    redirect = 1'b0; rob_full = 1'b0; rs_full = 4'h0;
    tick();
    chk("reset_state", 32'(state_dbg), 0);
    chk("reset_cnt", 32'(stall_cnt), 0);
    chk("reset_timeout", 32'(recover_timeout), 0);
    rst = 1'b0;

    // Free-list starvation
    for (int i = 0; i < 5; i++) begin
      settle();
      chk_ctl("starve", 1, 0, 0);
      stall_tick();
    end
    chk("starve_cnt", 32'(stall_cnt), 32'd5);
    fl_count = 7'd3;
    settle();
    chk_ctl("freed", 0, 0, 1);
    tick();
    chk("freed_cnt", 32'(stall_cnt), 32'd5);

    // RS full and FU type decode
    rn_futype = 3'd2; rs_full = 4'b0010;
    settle();
    chk_ctl("rs_full_mem", 1, 0, 0);
    stall_tick();
    rn_futype = 3'd4;
    settle();
    chk_ctl("rs_free_mul", 0, 0, 1);
    rn_futype = 3'd0;
    settle();
    chk_ctl("no_rs_type", 0, 0, 1);
    rn_futype = 3'd6;
    settle();
    chk_ctl("bad_type", 1, 0, 0);
    stall_tick();
    chk("rs_cnt", 32'(stall_cnt), 32'(exp_cnt));
    rn_futype = 3'd1; rs_full = 4'h0; rn_regwrite = 1'b0;

    // Redirect while ROB-full stall pending
    rob_full = 1'b1;
    settle();
    chk_ctl("pre_redirect", 1, 0, 0);
    stall_tick();
    redirect = 1'b1;
    settle();
    chk_ctl("redir_T", 0, 1, 0);
    chk("redir_T_restore", 32'(map_restore), 0);
    tick();
    redirect = 1'b0;
    settle();
    chk("T1_state", 32'(state_dbg), 1);
    chk("T1_restore", 32'(map_restore), 1);
    chk_ctl("T1", 0, 1, 0);
    tick();
    chk("T2_state", 32'(state_dbg), 2);
    chk("T2_restore", 32'(map_restore), 0);
    chk_ctl("T2", 0, 1, 0);
    tick();
    tick();
    restore_done = 1'b1;
    settle();
    chk("T4_state", 32'(state_dbg), 2);
    chk_ctl("T4", 0, 1, 0);
    tick();
    restore_done = 1'b0; rob_full = 1'b0;
    settle();
    chk("T5_state", 32'(state_dbg), 0);
    chk_ctl("T5", 0, 0, 1);
    chk("T5_cnt", 32'(stall_cnt), 32'(exp_cnt));

    // Second redirect during RECOVER, with a coincident restore_done
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    redirect = 1'b1; restore_done = 1'b1;
    settle();
    chk("re_T3_state", 32'(state_dbg), 2);
    tick();
    redirect = 1'b0; restore_done = 1'b0;
    settle();
    chk("re_T4_state", 32'(state_dbg), 1);
    chk("re_T4_restore", 32'(map_restore), 1);
    tick();

    // Timeout: 8 RECOVER cycles without restore_done
    for (int i = 0; i < 8; i++) begin
      chk("to_recover_state", 32'(state_dbg), 2);
      chk("to_timeout_low", 32'(recover_timeout), 0);
      tick();
    end
    chk("to_exit_state", 32'(state_dbg), 0);
    chk("to_flag", 32'(recover_timeout), 1);
    chk_ctl("to_run", 0, 0, 1);
    tick();
    tick();
    chk("to_sticky", 32'(recover_timeout), 1);

    // Counter saturation
    rob_full = 1'b1;
    for (int i = 0; i < 20; i++) stall_tick();
    chk("sat_cnt", 32'(stall_cnt), 32'd15);
    chk("sat_model", 32'(exp_cnt), 32'd15);

    // Reset mid-RECOVER
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    chk("pre_rst_state", 32'(state_dbg), 2);
    rst = 1'b1;
    settle();
    chk_ctl("rst_recover", 0, 0, 0);
    chk("rst_recover_restore", 32'(map_restore), 0);
    tick();
    rst = 1'b0; rob_full = 1'b0; rn_valid = 1'b0;
    settle();
    chk("post_rst_state", 32'(state_dbg), 0);
    chk("post_rst_cnt", 32'(stall_cnt), 0);
    chk("post_rst_timeout", 32'(recover_timeout), 0);
    chk_ctl("post_rst", 0, 0, 0);
    chk("post_rst_restore", 32'(map_restore), 0);
    tick();
    chk("post_rst_restore2", 32'(map_restore), 0);
    chk("post_rst_state2", 32'(state_dbg), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
